// File: rtl/pipelined_addsub_if.sv
// Operand/result stream between issue logic and the pipelined add/sub unit.
// master = producer of operands and consumer of results; slave = the arithmetic unit.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_ovf;
    logic             o_zero;

    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        input  o_in_ready, o_valid, o_result, o_cout, o_ovf, o_zero
    );

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
        output o_in_ready, o_valid, o_result, o_cout, o_ovf, o_zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Add/sub split into WIDTH/CHUNK carry-registered stages; latency WIDTH/CHUNK, 1 op/cycle, whole pipe freezes on o_valid & !i_ready.
// ADDSUB_SAT_EN: saturate o_result to the signed limit on overflow (flags stay unsaturated).
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipelined_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    logic adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // SW: operand bits not yet consumed; RW: result bits produced so far
        localparam int SW = WIDTH - k * CHUNK;
        localparam int RW = (k + 1) * CHUNK;

        logic [SW-1:0]  src_a;
        logic [SW-1:0]  src_b;
        logic           src_c;
        logic           src_v;
        logic [CHUNK:0] slice;
        logic [RW-1:0]  res_d;
        logic [RW-1:0]  res_q;
        logic           vld_q;
        logic           c_q;

        if (k == 0) begin : g_in
            assign src_v = bus.i_valid;
            assign src_a = bus.i_a;
            assign src_b = bus.i_sub ? ~bus.i_b : bus.i_b;
            assign src_c = bus.i_cin;
            assign res_d = slice[CHUNK-1:0];
        end else begin : g_in
            assign src_v = g_stage[k-1].vld_q;
            assign src_a = g_stage[k-1].g_out.a_q;
            assign src_b = g_stage[k-1].g_out.b_q;
            assign src_c = g_stage[k-1].c_q;
            assign res_d = {slice[CHUNK-1:0], g_stage[k-1].res_q};
        end

        assign slice = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, src_c};

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (adv) begin
                vld_q <= src_v;
                c_q   <= slice[CHUNK];
                res_q <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_out
            logic [SW-CHUNK-1:0] a_q;
            logic [SW-CHUNK-1:0] b_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= src_a[SW-1:CHUNK];
                    b_q <= src_b[SW-1:CHUNK];
                end
            end
        end else begin : g_last
            // src_b is already post-inversion, so this covers subtraction too
            logic ovf_d;
            logic ovf_q;
            logic zero_q;

            assign ovf_d = (src_a[SW-1] == src_b[SW-1]) & (res_d[RW-1] != src_a[SW-1]);

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= ovf_d;
                    zero_q <= ~|res_d;
                end
            end

`ifdef ADDSUB_SAT_EN
            logic amsb_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    amsb_q <= 1'b0;
                end else if (adv) begin
                    amsb_q <= src_a[SW-1];
                end
            end
`endif
        end
    end

    assign adv            = ~bus.o_valid | bus.i_ready;
    assign bus.o_in_ready = adv;
    assign bus.o_valid    = g_stage[STAGES-1].vld_q;
    assign bus.o_cout     = g_stage[STAGES-1].c_q;
    assign bus.o_ovf      = g_stage[STAGES-1].g_last.ovf_q;
    assign bus.o_zero     = g_stage[STAGES-1].g_last.zero_q;

`ifdef ADDSUB_SAT_EN
    // Positive overflow clamps to max, negative to min, chosen by A's sign
    logic sat_msb;
    assign sat_msb      = g_stage[STAGES-1].g_last.amsb_q;
    assign bus.o_result = bus.o_ovf ? {sat_msb, {(WIDTH-1){~sat_msb}}}
                                    : g_stage[STAGES-1].res_q;
`else
    assign bus.o_result = g_stage[STAGES-1].res_q;
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, CHUNK=8): directed, stall, reset and random traffic.
module tb_pipelined_addsub;
    localparam int W = 32;

`ifdef ADDSUB_SAT_EN
    localparam logic [31:0] SUB_OVF_RES = 32'h8000_0000;
    localparam logic [31:0] ADD_OVF_RES = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SUB_OVF_RES = 32'h7FFF_FFFF;
    localparam logic [31:0] ADD_OVF_RES = 32'h8000_0000;
`endif

    logic i_clk;
    logic i_rst;

    pipelined_addsub_if #(.WIDTH(W)) bus ();

    pipelined_addsub #(.WIDTH(W), .CHUNK(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        nxt;
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          rmode   = 0;
    bit          chk_lat = 1'b0;
    int          st_s    = -100;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
        exp_t e;
        e.res = r; e.cout = c; e.ovf = o; e.zero = z; e.cyc = 32'd0;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] s;
        exp_t        e;
        bb     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        e.res  = s[31:0];
        e.cout = s[32];
        e.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
        e.zero = (s[31:0] == 32'd0);
        e.cyc  = 32'd0;
`ifdef ADDSUB_SAT_EN
        if (e.ovf) e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    // One clock: drive ready, observe the handshakes that will fire at the next posedge
    task automatic step(output bit acc);
        bit   stall;
        exp_t e;
        stall = (rmode == 2) && (cyc >= st_s) && (cyc < st_s + 3);
        case (rmode)
            1:       bus.i_ready = 1'($urandom_range(0, 1));
            2:       bus.i_ready = !stall;
            default: bus.i_ready = 1'b1;
        endcase
        #1;
        acc = bus.i_valid && bus.o_in_ready;
        if (stall) begin
            chk("stall_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
            chk("stall_valid", {31'd0, bus.o_valid}, 32'd1);
            if (cyc == st_s) held = bus.o_result;
            else chk("stall_frozen", bus.o_result, held);
        end
        if (bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'd0, bus.o_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", bus.o_result, e.res);
                chk("cout", {31'd0, bus.o_cout}, {31'd0, e.cout});
                chk("ovf", {31'd0, bus.o_ovf}, {31'd0, e.ovf});
                chk("zero", {31'd0, bus.o_zero}, {31'd0, e.zero});
                if (chk_lat) chk("latency", 32'(cyc) - e.cyc, 32'd4);
            end
        end
        if (acc) begin
            e     = nxt;
            e.cyc = 32'(cyc);
            sb.push_back(e);
        end
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input exp_t e);
        bit acc;
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        bus.i_sub   = sub;
        nxt         = e;
        acc         = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) step(acc);
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 200 && sb.size() != 0; n++) step(acc);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit          acc;
        logic [31:0] ra, rb;
        logic        rs;

        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_cin   = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_cout", {31'd0, bus.o_cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
        chk("rst_zero", {31'd0, bus.o_zero}, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
        @(negedge i_clk);

        // Directed arithmetic cases, back-to-back with fixed latency
        rmode   = 0;
        chk_lat = 1'b1;
        send(32'd5,          32'd3,          1'b0, 1'b0, mk(32'd8,          1'b0, 1'b0, 1'b0));
        send(32'd5,          32'd3,          1'b1, 1'b0, mk(32'd9,          1'b0, 1'b0, 1'b0));
        send(32'd3,          32'd5,          1'b1, 1'b1, mk(32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0));
        send(32'd5,          32'd5,          1'b1, 1'b1, mk(32'd0,          1'b1, 1'b0, 1'b1));
        send(32'h8000_0000,  32'd1,          1'b1, 1'b1, mk(SUB_OVF_RES,    1'b1, 1'b1, 1'b0));
        send(32'h0000_00FF,  32'd1,          1'b0, 1'b0, mk(32'h0000_0100,  1'b0, 1'b0, 1'b0));
        send(32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, mk(32'd0,          1'b1, 1'b0, 1'b1));
        send(32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, mk(ADD_OVF_RES,    1'b0, 1'b1, 1'b0));
        drain();

        // Eight back-to-back ops with a 3-cycle downstream stall mid-stream
        rmode   = 2;
        chk_lat = 1'b0;
        st_s    = cyc + 5;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            send(ra, rb, 1'b0, 1'(i & 1), model(ra, rb, 1'b0, 1'(i & 1)));
        end
        drain();

        // Reset with ops in flight, the oldest already at the output
        rmode   = 0;
        chk_lat = 1'b1;
        send(32'd1, 32'd1, 1'b0, 1'b0, model(32'd1, 32'd1, 1'b0, 1'b0));
        send(32'd2, 32'd2, 1'b0, 1'b0, model(32'd2, 32'd2, 1'b0, 1'b0));
        send(32'd3, 32'd3, 1'b0, 1'b0, model(32'd3, 32'd3, 1'b0, 1'b0));
        step(acc);
        #1;
        chk("pre_rst_valid", {31'd0, bus.o_valid}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid_rst_result", bus.o_result, 32'd0);
        sb.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
        send(32'd9, 32'd1, 1'b0, 1'b0, mk(32'd10, 1'b0, 1'b0, 1'b0));
        drain();

        // Random traffic with random backpressure and input bubbles
        rmode   = 1;
        chk_lat = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) step(acc);
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rs, model(ra, rb, rs, rs));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
